// File: rtl/mix_pkg.sv
// Shared types and helpers for the I2S transmit mix scheduler.
package mix_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned SAT_W         = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COMMIT
  } state_e;

  // Clamp a sign-extended accumulator to the signed range of 'width' bits.
  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] acc,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(64'sd1) <<< (width - 1)) - SAT_W'(64'sd1);
    min_v = ~max_v;
    if (acc > max_v) begin
      return max_v;
    end else if (acc < min_v) begin
      return min_v;
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Combinational clamp of a mix accumulator to the output sample width.
module mix_saturate
  import mix_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 19,
  parameter int unsigned WIDTH     = DEFAULT_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc_i,
  output logic [WIDTH-1:0]     sat_c_o
);

  logic signed [SAT_W-1:0] acc_ext;

  always_comb begin
    acc_ext = {{(SAT_W - ACC_WIDTH){acc_i[ACC_WIDTH-1]}}, acc_i};
    sat_c_o = WIDTH'(sat_to_width(acc_ext, WIDTH));
  end

endmodule

// File: rtl/i2s_tx_mix_scheduler.sv
// Once per I2S frame, polls track sources round-robin, sums them with
// saturation and commits one stable stereo pair to the transmitter.
module i2s_tx_mix_scheduler
  import mix_pkg::*;
#(
  parameter int unsigned N_TRACKS  = 4,
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned ACC_WIDTH = WIDTH + $clog2(N_TRACKS) + 1
) (
  input  logic                      mclk,
  input  logic                      rst,
  input  logic                      ws,
  input  logic [N_TRACKS-1:0]       trk_enable,
  input  logic [N_TRACKS-1:0]       trk_valid,
  output logic [N_TRACKS-1:0]       trk_ready,
  input  logic [N_TRACKS*WIDTH-1:0] trk_data_l,
  input  logic [N_TRACKS*WIDTH-1:0] trk_data_r,
  input  logic                      master_mute,
  input  logic                      underrun_clr,
  output logic [WIDTH-1:0]          tx_data_l,
  output logic [WIDTH-1:0]          tx_data_r,
  output logic                      frame_done,
  output logic [N_TRACKS-1:0]       underrun,
  output logic                      overrun
);

  localparam int unsigned IDX_W = $clog2(N_TRACKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TRACKS - 1);

  state_e                state_q, state_d;
  logic                  ws_q;
  logic                  tick_c;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_TRACKS-1:0]   en_q, en_d;
  logic [ACC_WIDTH-1:0]  acc_l_q, acc_l_d;
  logic [ACC_WIDTH-1:0]  acc_r_q, acc_r_d;
  logic [WIDTH-1:0]      tx_l_q, tx_l_d;
  logic [WIDTH-1:0]      tx_r_q, tx_r_d;
  logic                  frame_done_q, frame_done_d;
  logic [N_TRACKS-1:0]   underrun_q, underrun_d;
  logic                  overrun_q, overrun_d;
  logic [WIDTH-1:0]      sat_l_c, sat_r_c;
  logic [WIDTH-1:0]      smp_l_c, smp_r_c;
  logic [WIDTH-1:0]      trk_l_a [N_TRACKS];
  logic [WIDTH-1:0]      trk_r_a [N_TRACKS];

  // Frame tick is the ws falling edge.
  assign tick_c = ws_q & ~ws;

  always_comb begin
    for (int i = 0; i < N_TRACKS; i++) begin
      trk_l_a[i] = trk_data_l[i*WIDTH +: WIDTH];
      trk_r_a[i] = trk_data_r[i*WIDTH +: WIDTH];
    end
    smp_l_c = trk_l_a[idx_q];
    smp_r_c = trk_r_a[idx_q];
  end

  // Ready follows state directly so a reset withdraws it in the same cycle.
  always_comb begin
    trk_ready = '0;
    if (state_q == FETCH) begin
      trk_ready[idx_q] = en_q[idx_q];
    end
  end

  mix_saturate #(.ACC_WIDTH(ACC_WIDTH), .WIDTH(WIDTH)) u_sat_l (
    .acc_i   (acc_l_q),
    .sat_c_o (sat_l_c)
  );

  mix_saturate #(.ACC_WIDTH(ACC_WIDTH), .WIDTH(WIDTH)) u_sat_r (
    .acc_i   (acc_r_q),
    .sat_c_o (sat_r_c)
  );

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ws_q         <= 1'b0;
      idx_q        <= '0;
      en_q         <= '0;
      acc_l_q      <= '0;
      acc_r_q      <= '0;
      tx_l_q       <= '0;
      tx_r_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ws_q         <= ws;
      idx_q        <= idx_d;
      en_q         <= en_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      tx_l_q       <= tx_l_d;
      tx_r_q       <= tx_r_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
      overrun_q    <= overrun_d;
    end
  end

  // Clears are applied first so a coincident set wins.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    en_d         = en_q;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    tx_l_d       = tx_l_q;
    tx_r_d       = tx_r_q;
    frame_done_d = 1'b0;
    underrun_d   = underrun_clr ? '0 : underrun_q;
    overrun_d    = underrun_clr ? 1'b0 : overrun_q;

    if (tick_c && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick_c) begin
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          en_d    = trk_enable;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (en_q[idx_q]) begin
          if (trk_valid[idx_q]) begin
            acc_l_d = acc_l_q + {{(ACC_WIDTH - WIDTH){smp_l_c[WIDTH-1]}}, smp_l_c};
            acc_r_d = acc_r_q + {{(ACC_WIDTH - WIDTH){smp_r_c[WIDTH-1]}}, smp_r_c};
          end else begin
            underrun_d[idx_q] = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      COMMIT: begin
        tx_l_d       = master_mute ? '0 : sat_l_c;
        tx_r_d       = master_mute ? '0 : sat_r_c;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_data_l  = tx_l_q;
  assign tx_data_r  = tx_r_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_tx_mix_scheduler.sv
// Self-checking bench for i2s_tx_mix_scheduler: vector table plus hand-written
// overrun, set-wins and reset-abort sequences, with a commit scoreboard.
module tb_i2s_tx_mix_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic           mclk = 1'b0;
  logic           rst = 1'b0;
  logic           ws = 1'b0;
  logic [N-1:0]   trk_enable = '0;
  logic [N-1:0]   trk_valid = '0;
  logic [N-1:0]   trk_ready;
  logic [N*W-1:0] trk_data_l = '0;
  logic [N*W-1:0] trk_data_r = '0;
  logic           master_mute = 1'b0;
  logic           underrun_clr = 1'b0;
  logic [W-1:0]   tx_data_l;
  logic [W-1:0]   tx_data_r;
  logic           frame_done;
  logic [N-1:0]   underrun;
  logic           overrun;

  always #5 mclk = ~mclk;

  i2s_tx_mix_scheduler dut (
    .mclk         (mclk),
    .rst          (rst),
    .ws           (ws),
    .trk_enable   (trk_enable),
    .trk_valid    (trk_valid),
    .trk_ready    (trk_ready),
    .trk_data_l   (trk_data_l),
    .trk_data_r   (trk_data_r),
    .master_mute  (master_mute),
    .underrun_clr (underrun_clr),
    .tx_data_l    (tx_data_l),
    .tx_data_r    (tx_data_r),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  typedef struct {
    string        name;
    logic [N-1:0] en;
    logic [N-1:0] valid;
    logic         mute;
    logic [N*W-1:0] dl;
    logic [N*W-1:0] dr;
    logic [W-1:0] exp_l;
    logic [W-1:0] exp_r;
    logic [N-1:0] exp_unr;
  } vec_t;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } exp_t;

  vec_t   vecs[8];
  exp_t   sb_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     commits = 0;
  logic [W-1:0] prev_l = '0;
  logic [W-1:0] prev_r = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_cycle();
    @(posedge mclk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] l, input logic [W-1:0] r);
    exp_t e;
    e.l = l;
    e.r = r;
    sb_q.push_back(e);
  endtask

  task automatic apply_inputs(input vec_t v);
    trk_enable  = v.en;
    trk_valid   = v.valid;
    master_mute = v.mute;
    trk_data_l  = v.dl;
    trk_data_r  = v.dr;
  endtask

  task automatic wait_commit(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge mclk);
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    check({name, "_commit_seen"}, 32'(seen), 32'd1);
  endtask

  // Commit scoreboard and tx hold check.
  always @(negedge mclk) begin
    if (!rst) begin
      prev_l <= '0;
      prev_r <= '0;
    end else begin
      if (!frame_done) begin
        check("tx_hold_l", 32'(tx_data_l), 32'(prev_l));
        check("tx_hold_r", 32'(tx_data_r), 32'(prev_r));
      end else if (sb_q.size() == 0) begin
        check("unexpected_commit", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("tx_data_l", 32'(tx_data_l), 32'(mon_e.l));
        check("tx_data_r", 32'(tx_data_r), 32'(mon_e.r));
        commits <= commits + 1;
      end
      prev_l <= tx_data_l;
      prev_r <= tx_data_r;
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    int hs;
    logic rdy_bad;
    logic [N-1:0] exp_rdy;
    apply_inputs(v);
    ws = 1'b1;
    repeat (3) tick_cycle();
    push_exp(v.exp_l, v.exp_r);
    ws = 1'b0;
    lat = -1;
    hs = 0;
    rdy_bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge mclk);
      exp_rdy = '0;
      if (k >= 1 && k <= N) exp_rdy[k-1] = v.en[k-1];
      if (trk_ready !== exp_rdy) rdy_bad = 1'b1;
      hs += $countones(trk_ready & trk_valid);
      if (frame_done) begin
        lat = k;
        break;
      end
    end
    check({v.name, "_latency"}, 32'(lat), 32'd6);
    check({v.name, "_ready_seq_bad"}, 32'(rdy_bad), 32'd0);
    check({v.name, "_handshakes"}, 32'(hs), 32'($countones(v.en & v.valid)));
    tick_cycle();
    check({v.name, "_underrun"}, 32'(underrun), 32'(v.exp_unr));
    check({v.name, "_overrun"}, 32'(overrun), 32'd0);
    underrun_clr = 1'b1;
    tick_cycle();
    underrun_clr = 1'b0;
    check({v.name, "_underrun_cleared"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int c0;
    vecs[0] = '{"basic", 4'hF, 4'hF, 1'b0, {16'd10, 16'hFFCE, 16'd200, 16'd100},
                {4{16'hFFFF}}, 16'd260, 16'hFFFC, 4'h0};
    vecs[1] = '{"sat", 4'hF, 4'hF, 1'b0, {4{16'h7000}}, {4{16'h9000}},
                16'h7FFF, 16'h8000, 4'h0};
    vecs[2] = '{"underrun", 4'hF, 4'b1011, 1'b0, {16'd1, 16'd5, 16'd1, 16'd1},
                64'h0, 16'd3, 16'd0, 4'b0100};
    vecs[3] = '{"mute", 4'b0011, 4'hF, 1'b1, {16'd4, 16'd3, 16'd2, 16'd1},
                {4{16'h0005}}, 16'd0, 16'd0, 4'h0};
    vecs[4] = '{"partial", 4'b0101, 4'hF, 1'b0, {16'd40, 16'd30, 16'd20, 16'd10},
                {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF}, 16'd40, 16'hFFFC, 4'h0};
    vecs[5] = '{"none", 4'h0, 4'hF, 1'b0, {4{16'h1234}}, {4{16'h1234}},
                16'd0, 16'd0, 4'h0};
    vecs[6] = '{"edge_exact", 4'hF, 4'hF, 1'b0, {16'h0001, 16'hFFFF, 16'h7FFF, 16'h0000},
                {16'h8000, 16'h0000, 16'h0000, 16'h0000}, 16'h7FFF, 16'h8000, 4'h0};
    vecs[7] = '{"edge_over", 4'hF, 4'hF, 1'b0, {16'h0001, 16'h0000, 16'h7FFF, 16'h0000},
                {16'hFFFF, 16'h0000, 16'h8000, 16'h0000}, 16'h7FFF, 16'h8000, 4'h0};

    repeat (3) tick_cycle();
    check("rst_tx_l", 32'(tx_data_l), 32'd0);
    check("rst_tx_r", 32'(tx_data_r), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ready", 32'(trk_ready), 32'd0);
    rst = 1'b1;
    tick_cycle();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Second ws falling edge two cycles into the sequence.
    apply_inputs(vecs[0]);
    ws = 1'b1;
    repeat (3) tick_cycle();
    c0 = commits;
    push_exp(16'd260, 16'hFFFC);
    ws = 1'b0;
    tick_cycle();
    ws = 1'b1;
    tick_cycle();
    ws = 1'b0;
    wait_commit("overrun");
    repeat (12) tick_cycle();
    check("overrun_set", 32'(overrun), 32'd1);
    check("overrun_single_commit", 32'(commits - c0), 32'd1);
    ws = 1'b1;
    repeat (6) tick_cycle();
    check("ws_rise_hold_l", 32'(tx_data_l), 32'd260);
    underrun_clr = 1'b1;
    tick_cycle();
    underrun_clr = 1'b0;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Clear pulse coincides with the track-2 underrun set.
    apply_inputs(vecs[2]);
    ws = 1'b1;
    repeat (3) tick_cycle();
    push_exp(16'd3, 16'd0);
    ws = 1'b0;
    repeat (3) tick_cycle();
    underrun_clr = 1'b1;
    tick_cycle();
    underrun_clr = 1'b0;
    check("set_wins_underrun", 32'(underrun), 32'h4);
    wait_commit("set_wins");
    tick_cycle();
    check("set_wins_underrun_held", 32'(underrun), 32'h4);
    underrun_clr = 1'b1;
    tick_cycle();
    underrun_clr = 1'b0;

    // Reset two cycles after the tick aborts the sequence.
    apply_inputs(vecs[0]);
    ws = 1'b1;
    repeat (3) tick_cycle();
    ws = 1'b0;
    repeat (2) tick_cycle();
    rst = 1'b0;
    #1;
    check("midrst_tx_l", 32'(tx_data_l), 32'd0);
    check("midrst_tx_r", 32'(tx_data_r), 32'd0);
    check("midrst_ready", 32'(trk_ready), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    repeat (2) tick_cycle();
    rst = 1'b1;
    repeat (10) tick_cycle();
    check("midrst_no_commit_tx_l", 32'(tx_data_l), 32'd0);
    run_vec(vecs[0]);

    repeat (10) tick_cycle();
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
